// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multicycle control FSM for a data-memory/register-file datapath.
// Fetches 16-bit instructions, decodes them and sequences the datapath strobes.
//   clk, rst_n       : clock, synchronous active-low reset
//   I_data           : instruction-memory read data (valid the cycle after I_rd)
//   I_addr, I_rd     : instruction-memory address (PC) and read enable
//   D_addr           : data-memory address (IR[7:0])
//   Dmem_write       : data-memory write enable (stores register port A)
//   Reg_write        : register-file write enable
//   Reg_w_addr       : register-file write address (rd)
//   Reg_Ra_addr      : register-file read address A (rd)
//   Reg_Rb_addr      : register-file read address B (rs)
//   RF_sel           : write-back select, 0 = ALU, 1 = data-memory q
//   ALU_op           : 00 pass A, 01 add, 10 sub
//   halted           : high while stopped on a HALT instruction
module cpu_control_unit #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned DADDR_W = 8,
  parameter int unsigned RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        I_data,
  output logic [PC_W-1:0]    I_addr,
  output logic               I_rd,
  output logic [DADDR_W-1:0] D_addr,
  output logic               Dmem_write,
  output logic               Reg_write,
  output logic [RADDR_W-1:0] Reg_w_addr,
  output logic [RADDR_W-1:0] Reg_Ra_addr,
  output logic [RADDR_W-1:0] Reg_Rb_addr,
  output logic               RF_sel,
  output logic [1:0]         ALU_op,
  output logic               halted
);

  localparam logic [3:0] StFetch  = 4'd0;
  localparam logic [3:0] StFetchW = 4'd1;
  localparam logic [3:0] StDecode = 4'd2;
  localparam logic [3:0] StNoop   = 4'd3;
  localparam logic [3:0] StStore  = 4'd4;
  localparam logic [3:0] StLoadA  = 4'd5;
  localparam logic [3:0] StLoadB  = 4'd6;
  localparam logic [3:0] StAdd    = 4'd7;
  localparam logic [3:0] StSub    = 4'd8;
  localparam logic [3:0] StHalt   = 4'd9;

  localparam logic [2:0] OpStore = 3'b001;
  localparam logic [2:0] OpLoad  = 3'b010;
  localparam logic [2:0] OpAdd   = 3'b011;
  localparam logic [2:0] OpSub   = 3'b100;
  localparam logic [2:0] OpHalt  = 3'b111;

  logic [3:0]      r_state;
  logic [3:0]      w_state_next;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_ir;
  logic [2:0]      w_op;

  assign w_op = r_ir[15:13];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StFetch;
      r_pc    <= '0;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StFetchW) begin
        r_ir <= I_data;
        r_pc <= r_pc + {{(PC_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_comb begin
    w_state_next = StFetch;
    case (r_state)
      StFetch:  w_state_next = StFetchW;
      StFetchW: w_state_next = StDecode;
      StDecode: begin
        case (w_op)
          OpStore: w_state_next = StStore;
          OpLoad:  w_state_next = StLoadA;
          OpAdd:   w_state_next = StAdd;
          OpSub:   w_state_next = StSub;
          OpHalt:  w_state_next = StHalt;
          default: w_state_next = StNoop;  // 000, 101, 110
        endcase
      end
      StLoadA:  w_state_next = StLoadB;
      StHalt:   w_state_next = StHalt;
      // NOOP, STORE, LOAD_B, ADD, SUB and unused encodings return to FETCH
      default:  w_state_next = StFetch;
    endcase
  end

  // Addresses always follow the IR fields; only strobes and selects depend on state.
  always_comb begin
    I_addr      = r_pc;
    I_rd        = 1'b0;
    D_addr      = r_ir[DADDR_W-1:0];
    Dmem_write  = 1'b0;
    Reg_write   = 1'b0;
    Reg_w_addr  = r_ir[8 +: RADDR_W];
    Reg_Ra_addr = r_ir[8 +: RADDR_W];
    Reg_Rb_addr = r_ir[3 +: RADDR_W];
    RF_sel      = 1'b0;
    ALU_op      = 2'b00;
    halted      = 1'b0;
    case (r_state)
      StFetch: I_rd = 1'b1;
      StStore: Dmem_write = 1'b1;
      StLoadB: begin
        RF_sel    = 1'b1;
        Reg_write = 1'b1;
      end
      StAdd: begin
        ALU_op    = 2'b01;
        Reg_write = 1'b1;
      end
      StSub: begin
        ALU_op    = 2'b10;
        Reg_write = 1'b1;
      end
      StHalt:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
module tb_cpu_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] I_data = 16'h0000;
  logic [7:0]  I_addr;
  logic        I_rd;
  logic [7:0]  D_addr;
  logic        Dmem_write;
  logic        Reg_write;
  logic [4:0]  Reg_w_addr;
  logic [4:0]  Reg_Ra_addr;
  logic [4:0]  Reg_Rb_addr;
  logic        RF_sel;
  logic [1:0]  ALU_op;
  logic        halted;

  cpu_control_unit #(.PC_W(8), .DADDR_W(8), .RADDR_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .I_data      (I_data),
    .I_addr      (I_addr),
    .I_rd        (I_rd),
    .D_addr      (D_addr),
    .Dmem_write  (Dmem_write),
    .Reg_write   (Reg_write),
    .Reg_w_addr  (Reg_w_addr),
    .Reg_Ra_addr (Reg_Ra_addr),
    .Reg_Rb_addr (Reg_Rb_addr),
    .RF_sel      (RF_sel),
    .ALU_op      (ALU_op),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Registered instruction memory: data appears the cycle after I_rd.
  logic [15:0] imem [256];
  always @(posedge clk) if (I_rd) I_data <= imem[I_addr];

  typedef struct packed {
    logic [7:0] i_addr;
    logic       i_rd;
    logic [7:0] d_addr;
    logic       dw;
    logic       rw;
    logic [4:0] wa;
    logic [4:0] ra;
    logic [4:0] rb;
    logic       sel;
    logic [1:0] alu;
    logic       hlt;
  } rec_t;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: a queue of expected per-cycle output snapshots,
  // expanded one instruction at a time from the program and the ISA timing.
  rec_t        q[$];
  logic [7:0]  m_pc;
  logic [15:0] m_ir;
  bit          m_halted;
  bit          m_valid = 0;

  function automatic rec_t base(input logic [7:0] pc, input logic [15:0] ir);
    rec_t r;
    r = '0;
    r.i_addr = pc;
    r.d_addr = ir[7:0];
    r.wa     = ir[12:8];
    r.ra     = ir[12:8];
    r.rb     = ir[7:3];
    return r;
  endfunction

  task automatic refill();
    rec_t r;
    if (m_halted) begin
      r = base(m_pc, m_ir);
      r.hlt = 1'b1;
      q.push_back(r);
      return;
    end
    r = base(m_pc, m_ir); r.i_rd = 1'b1; q.push_back(r);   // fetch
    r = base(m_pc, m_ir); q.push_back(r);                  // wait for memory
    m_ir = imem[m_pc];
    m_pc = m_pc + 8'd1;
    r = base(m_pc, m_ir); q.push_back(r);                  // decode
    r = base(m_pc, m_ir);
    case (m_ir[15:13])
      3'b001: begin r.dw = 1'b1; q.push_back(r); end
      3'b010: begin
        q.push_back(r);
        r.rw = 1'b1; r.sel = 1'b1; q.push_back(r);
      end
      3'b011: begin r.rw = 1'b1; r.alu = 2'b01; q.push_back(r); end
      3'b100: begin r.rw = 1'b1; r.alu = 2'b10; q.push_back(r); end
      3'b111: begin r.hlt = 1'b1; m_halted = 1; q.push_back(r); end
      default: q.push_back(r);
    endcase
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      q.delete();
      m_pc = 8'd0; m_ir = 16'd0; m_halted = 0; m_valid = 1;
    end else if (m_valid) begin
      void'(q.pop_front());
    end
    if (m_valid && q.size() == 0) refill();
  endtask

  task automatic compare();
    rec_t a;
    a = {I_addr, I_rd, D_addr, Dmem_write, Reg_write, Reg_w_addr, Reg_Ra_addr,
         Reg_Rb_addr, RF_sel, ALU_op, halted};
    if (!m_valid) return;
    n_cmp++;
    if (a !== q[0]) begin
      n_err++;
      $display("FAIL model_cycle t=%0t actual=%h expected=%h", $time, a, q[0]);
    end
    if (Dmem_write && Reg_write) begin
      n_err++;
      $display("FAIL excl_dw_rw t=%0t actual=11 expected=not both", $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic fill_noop();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
  endtask

  initial begin
    // Reset and LOAD r5,[0x12]
    fill_noop();
    imem[0] = 16'h4512;
    do_reset(2);
    lit("reset_iaddr", {24'd0, I_addr}, 32'h0);
    lit("reset_ird", {31'd0, I_rd}, 32'h1);
    lit("reset_enables", {29'd0, Dmem_write, Reg_write, halted}, 32'h0);
    repeat (4) tick();
    lit("load_b_daddr", {24'd0, D_addr}, 32'h12);
    lit("load_b_waddr", {27'd0, Reg_w_addr}, 32'h5);
    lit("load_b_sel_we", {30'd0, RF_sel, Reg_write}, 32'h3);
    tick();
    lit("load_next_fetch", {23'd0, I_rd, I_addr}, 32'h101);
    lit("load_we_one_cycle", {31'd0, Reg_write}, 32'h0);

    // STORE r3,[0x40] then ADD r1,r2
    fill_noop();
    imem[0] = 16'h2340;
    imem[1] = 16'h6110;
    do_reset(2);
    repeat (3) tick();
    lit("store_strobe", {15'd0, Dmem_write, D_addr, 3'd0, Reg_Ra_addr}, 32'h14003);
    tick();
    lit("store_4cyc_fetch", {23'd0, I_rd, I_addr}, 32'h101);
    repeat (3) tick();
    lit("add_ctrl", {16'd0, Reg_write, Reg_w_addr, Reg_Ra_addr, Reg_Rb_addr}, 32'h8422);
    lit("add_alu", {30'd0, ALU_op}, 32'h1);
    tick();
    lit("add_4cyc_fetch", {23'd0, I_rd, I_addr}, 32'h102);

    // Opcode 101 as NOOP, then HALT
    fill_noop();
    imem[0] = 16'hA000;
    imem[1] = 16'hE000;
    do_reset(2);
    repeat (4) tick();
    lit("op101_4cyc", {23'd0, I_rd, I_addr}, 32'h101);
    repeat (3) tick();
    lit("halt_entry", {31'd0, halted}, 32'h1);
    repeat (22) tick();
    lit("halt_persist", {22'd0, halted, I_rd, I_addr}, 32'h202);

    // PC wrap after fetching address 255
    fill_noop();
    do_reset(1);
    repeat (1020) tick();
    lit("fetch_255", {23'd0, I_rd, I_addr}, 32'h1FF);
    repeat (4) tick();
    lit("pc_wrap", {23'd0, I_rd, I_addr}, 32'h100);

    // Reset during LOAD_A
    fill_noop();
    imem[0] = 16'h4512;
    do_reset(2);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    lit("midload_reset", {22'd0, Reg_write, I_rd, I_addr}, 32'h100);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      lit("midload_no_write", {31'd0, Reg_write}, 32'h0);
    end

    // Random programs with occasional resets
    for (int i = 0; i < 256; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      if (op == 3'b111 && $urandom_range(0, 3) != 0) op = 3'b011;
      imem[i] = {op, 13'($urandom)};
    end
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      tick();
    end
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
